// File: rtl/ftdi_pkg.sv
// Shared types and defaults for the FTDI parallel-FIFO controller.
// Optional build macro FTDI_INPUT_SYNC_EN is consumed by ftdi_controller.
package ftdi_pkg;

    localparam int RD_CYCLES_DEF      = 3;
    localparam int WR_CYCLES_DEF      = 3;
    localparam int RECOVER_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_STROBE,
        RD_DELIVER,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        WR_ACK,
        RECOVER
    } ftdi_state_e;

    typedef struct packed {
        ftdi_state_e state;
        logic        bus_oe;
        logic        prio_rd;
    } ftdi_dbg_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/ftdi_sync2.sv
// Two-flop synchronizer for the FTDI status flags; EN=0 passes the input straight through.
module ftdi_sync2 #(
    parameter bit EN = 1'b1
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_d,
    output logic out_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= in_d;
            sync_q <= meta_q;
        end
    end

    assign out_q = EN ? sync_q : in_d;

endmodule

// File: rtl/ftdi_controller.sv
// FTDI parallel-FIFO bridge: strobed byte reads/writes on a shared bus, 4-phase user handshakes.
// Define FTDI_INPUT_SYNC_EN to pass in_ftdi_txe/in_ftdi_rxf through 2-flop synchronizers.
module ftdi_controller
    import ftdi_pkg::*;
#(
    parameter int RD_CYCLES      = RD_CYCLES_DEF,
    parameter int WR_CYCLES      = WR_CYCLES_DEF,
    parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_ftdi_txe,
    input  logic       in_ftdi_rxf,
    inout  wire  [7:0] io_ftdi_data,
    output logic       out_ftdi_wr,
    output logic       out_ftdi_rd,
    input  logic       in_rx_en,
    input  logic       in_tx_hsk_req,
    output logic       out_tx_hsk_ack,
    input  logic [7:0] in_tx_data,
    output logic [7:0] out_rx_data,
    output logic       out_rx_hsk_req,
    input  logic       in_rx_hsk_ack,
    output ftdi_dbg_t  out_dbg
);

`ifdef FTDI_INPUT_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(max3(RD_CYCLES, WR_CYCLES, RECOVER_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVER_CYCLES - 1);

    logic rxf_s;
    logic txe_s;

    ftdi_sync2 #(.EN(SYNC_EN)) u_sync_rxf (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .in_d   (in_ftdi_rxf),
        .out_q  (rxf_s)
    );

    ftdi_sync2 #(.EN(SYNC_EN)) u_sync_txe (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .in_d   (in_ftdi_txe),
        .out_q  (txe_s)
    );

    ftdi_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rd_q;
    logic             wr_q;
    logic             oe_q;
    logic             tx_ack_q;
    logic             rx_req_q;
    logic [7:0]       rx_data_q;
    logic [7:0]       tx_byte_q;
    logic             prio_rd_q;

    logic rd_cand;
    logic wr_cand;

    assign rd_cand = rxf_s && in_rx_en;
    assign wr_cand = in_tx_hsk_req && txe_s;

    // cnt_q counts down to zero; each timed state lasts LOAD+1 cycles.
    // prio_rd_q is set after a write (or reset) so a tie goes to the read.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            oe_q      <= 1'b0;
            tx_ack_q  <= 1'b0;
            rx_req_q  <= 1'b0;
            rx_data_q <= 8'h00;
            tx_byte_q <= 8'h00;
            prio_rd_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_cand && (prio_rd_q || !wr_cand)) begin
                        state_q   <= RD_STROBE;
                        rd_q      <= 1'b1;
                        cnt_q     <= RD_LOAD;
                        prio_rd_q <= 1'b0;
                    end else if (wr_cand) begin
                        state_q   <= WR_SETUP;
                        oe_q      <= 1'b1;
                        tx_byte_q <= in_tx_data;
                        prio_rd_q <= 1'b1;
                    end
                end
                RD_STROBE: begin
                    if (cnt_q == '0) begin
                        rx_data_q <= io_ftdi_data;
                        rd_q      <= 1'b0;
                        rx_req_q  <= 1'b1;
                        state_q   <= RD_DELIVER;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RD_DELIVER: begin
                    // rx_req_q doubles as the sub-phase: high = waiting ack, low = waiting ack release
                    if (rx_req_q) begin
                        if (in_rx_hsk_ack) rx_req_q <= 1'b0;
                    end else if (!in_rx_hsk_ack) begin
                        state_q <= RECOVER;
                        cnt_q   <= REC_LOAD;
                    end
                end
                WR_SETUP: begin
                    state_q <= WR_STROBE;
                    wr_q    <= 1'b1;
                    cnt_q   <= WR_LOAD;
                end
                WR_STROBE: begin
                    if (cnt_q == '0) begin
                        wr_q    <= 1'b0;
                        state_q <= WR_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WR_HOLD: begin
                    oe_q     <= 1'b0;
                    tx_ack_q <= 1'b1;
                    state_q  <= WR_ACK;
                end
                WR_ACK: begin
                    if (!in_tx_hsk_req) begin
                        tx_ack_q <= 1'b0;
                        state_q  <= RECOVER;
                        cnt_q    <= REC_LOAD;
                    end
                end
                RECOVER: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io_ftdi_data   = oe_q ? tx_byte_q : 8'bz;
    assign out_ftdi_rd    = rd_q;
    assign out_ftdi_wr    = wr_q;
    assign out_tx_hsk_ack = tx_ack_q;
    assign out_rx_hsk_req = rx_req_q;
    assign out_rx_data    = rx_data_q;

    assign out_dbg.state   = state_q;
    assign out_dbg.bus_oe  = oe_q;
    assign out_dbg.prio_rd = prio_rd_q;

endmodule

// File: tb/tb_ftdi_controller.sv
// Bench for ftdi_controller: FTDI FIFO model, user-side handshake drivers, pulse monitor, per-scenario checks.
module tb_ftdi_controller;
    import ftdi_pkg::*;

    localparam int RD_CYC  = 3;
    localparam int WR_CYC  = 3;
    localparam int REC_CYC = 4;

    logic       in_clk        = 1'b0;
    logic       in_rst        = 1'b1;
    logic       in_ftdi_txe   = 1'b0;
    logic       in_ftdi_rxf   = 1'b0;
    logic       in_rx_en      = 1'b0;
    logic       in_tx_hsk_req = 1'b0;
    logic       in_rx_hsk_ack = 1'b0;
    logic [7:0] in_tx_data    = 8'h00;
    wire  [7:0] ftdi_bus;
    logic       out_ftdi_wr;
    logic       out_ftdi_rd;
    logic       out_tx_hsk_ack;
    logic       out_rx_hsk_req;
    logic [7:0] out_rx_data;
    ftdi_dbg_t  out_dbg;

    int n_cmp = 0;
    int n_err = 0;

    ftdi_controller #(
        .RD_CYCLES      (RD_CYC),
        .WR_CYCLES      (WR_CYC),
        .RECOVER_CYCLES (REC_CYC)
    ) dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_ftdi_txe    (in_ftdi_txe),
        .in_ftdi_rxf    (in_ftdi_rxf),
        .io_ftdi_data   (ftdi_bus),
        .out_ftdi_wr    (out_ftdi_wr),
        .out_ftdi_rd    (out_ftdi_rd),
        .in_rx_en       (in_rx_en),
        .in_tx_hsk_req  (in_tx_hsk_req),
        .out_tx_hsk_ack (out_tx_hsk_ack),
        .in_tx_data     (in_tx_data),
        .out_rx_data    (out_rx_data),
        .out_rx_hsk_req (out_rx_hsk_req),
        .in_rx_hsk_ack  (in_rx_hsk_ack),
        .out_dbg        (out_dbg)
    );

    // Clock / watchdog
    always #5 in_clk = ~in_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    // FTDI FIFO model: drives the bus while rd is high, pops a byte on each rd pulse
    logic [7:0] ftdi_q[$];
    logic [7:0] ftdi_cur = 8'h00;
    bit         ftdi_en  = 1'b0;

    assign ftdi_bus = out_ftdi_rd ? ftdi_cur : 8'bz;

    // Observed traffic, sampled on the falling edge
    int         rd_pulses, wr_pulses, viol, rx_unstable, req_cycles, ack_cycles;
    int         rd_width_q[$];
    int         wr_width_q[$];
    int         rd_gap_q[$];
    logic [7:0] wr_byte_q[$];
    logic [7:0] wr_pre_q[$];
    logic [7:0] wr_post_q[$];
    bit         order_q[$];     // 0 = read pulse, 1 = write pulse
    bit         mon_seen_rd;
    logic [7:0] rx_got_q[$];
    logic [7:0] exp_q[$];

    bit         m_prev_rd, m_prev_wr, m_prev_req;
    int         m_rd_w, m_wr_w, m_gap;
    logic [7:0] m_prev_bus, m_last_wr_bus, m_prev_rx;

    initial begin
        forever begin
            @(negedge in_clk);
            if (out_ftdi_rd && out_ftdi_wr) viol++;
            if (out_ftdi_rd && out_dbg.bus_oe) viol++;
            if (out_ftdi_rd) begin
                if (!m_prev_rd) begin
                    order_q.push_back(1'b0);
                    rd_pulses++;
                    if (mon_seen_rd) rd_gap_q.push_back(m_gap);
                end
                m_rd_w++;
            end else if (m_prev_rd) begin
                rd_width_q.push_back(m_rd_w);
                m_rd_w = 0;
                m_gap = 1;
                mon_seen_rd = 1'b1;
                if (ftdi_q.size() != 0) void'(ftdi_q.pop_front());
            end else begin
                m_gap++;
            end
            if (out_ftdi_wr) begin
                if (!m_prev_wr) begin
                    order_q.push_back(1'b1);
                    wr_pulses++;
                    wr_pre_q.push_back(m_prev_bus);
                end
                m_wr_w++;
                m_last_wr_bus = ftdi_bus;
            end else if (m_prev_wr) begin
                wr_width_q.push_back(m_wr_w);
                wr_byte_q.push_back(m_last_wr_bus);
                wr_post_q.push_back(ftdi_bus);
                m_wr_w = 0;
            end
            if (out_rx_hsk_req) begin
                req_cycles++;
                if (m_prev_req && out_rx_data !== m_prev_rx) rx_unstable++;
            end
            if (out_tx_hsk_ack) ack_cycles++;
            m_prev_rd  = out_ftdi_rd;
            m_prev_wr  = out_ftdi_wr;
            m_prev_req = out_rx_hsk_req;
            m_prev_rx  = out_rx_data;
            m_prev_bus = ftdi_bus;
            ftdi_cur    = (ftdi_q.size() != 0) ? ftdi_q[0] : 8'h00;
            in_ftdi_rxf = ftdi_en && (ftdi_q.size() != 0);
        end
    end

    // User receive side: takes each delivered byte and completes the 4-phase handshake
    initial begin
        forever begin
            @(negedge in_clk);
            if (out_rx_hsk_req && !in_rx_hsk_ack) begin
                rx_got_q.push_back(out_rx_data);
                repeat ($urandom_range(0, 3)) @(negedge in_clk);
                in_rx_hsk_ack = 1'b1;
            end else if (in_rx_hsk_ack && !out_rx_hsk_req) begin
                repeat ($urandom_range(0, 2)) @(negedge in_clk);
                in_rx_hsk_ack = 1'b0;
            end
        end
    end

    // Driver tasks
    task automatic clear_mon();
        rd_pulses = 0; wr_pulses = 0; viol = 0; rx_unstable = 0; req_cycles = 0; ack_cycles = 0;
        rd_width_q.delete(); wr_width_q.delete(); rd_gap_q.delete();
        wr_byte_q.delete(); wr_pre_q.delete(); wr_post_q.delete();
        order_q.delete(); rx_got_q.delete(); exp_q.delete();
        mon_seen_rd = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        in_rst = 1'b1;
        repeat (cycles) @(negedge in_clk);
        in_rst = 1'b0;
    endtask

    task automatic tx_transfer(input logic [7:0] d, input int hold,
                               output int ack_lat, output bit held, output bit to);
        int n;
        to = 1'b0; held = 1'b1; ack_lat = -1;
        in_tx_data = d;
        in_tx_hsk_req = 1'b1;
        n = 0;
        while (!out_tx_hsk_ack && n < 2000) begin @(negedge in_clk); n++; end
        if (!out_tx_hsk_ack) begin
            to = 1'b1;
            in_tx_hsk_req = 1'b0;
            return;
        end
        repeat (hold) begin
            @(negedge in_clk);
            if (!out_tx_hsk_ack) held = 1'b0;
        end
        in_tx_hsk_req = 1'b0;
        n = 0;
        do begin @(negedge in_clk); n++; end while (out_tx_hsk_ack && n < 50);
        ack_lat = n;
    endtask

    task automatic wait_rx(input int n, output bit to);
        int c;
        c = 0;
        while (rx_got_q.size() < n && c < 3000) begin @(negedge in_clk); c++; end
        to = (rx_got_q.size() < n);
        repeat (12) @(negedge in_clk);
    endtask

    // Scenarios
    task automatic test_reset();
        in_rst = 1'b1;
        repeat (4) @(negedge in_clk);
        n_cmp++; if (out_ftdi_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %0b want 0", out_ftdi_rd); end
        n_cmp++; if (out_ftdi_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr: got %0b want 0", out_ftdi_wr); end
        n_cmp++; if (out_dbg.bus_oe !== 1'b0) begin n_err++; $display("FAIL reset_bus_z: drive=%0b want 0", out_dbg.bus_oe); end
        n_cmp++; if (out_rx_hsk_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b want 0", out_rx_hsk_req); end
        n_cmp++; if (out_tx_hsk_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %0b want 0", out_tx_hsk_ack); end
        n_cmp++; if (out_rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %02h want 00", out_rx_data); end
        n_cmp++; if (out_dbg.state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", out_dbg.state, IDLE); end
        in_rst = 1'b0;
        @(negedge in_clk);
    endtask

    task automatic test_read_stream(input int n, input bit rnd);
        bit to;
        logic [7:0] b;
        clear_mon();
        for (int i = 0; i < n; i++) begin
            b = rnd ? 8'($urandom) : 8'(i);
            exp_q.push_back(b);
            ftdi_q.push_back(b);
        end
        in_rx_en = 1'b1;
        ftdi_en  = 1'b1;
        wait_rx(n, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL read_timeout: got %0d bytes want %0d", rx_got_q.size(), n); end
        n_cmp++; if (rd_pulses != n) begin n_err++; $display("FAIL read_pulse_count: got %0d want %0d", rd_pulses, n); end
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (i >= rx_got_q.size()) begin
                n_err++; $display("FAIL read_byte[%0d]: got none want %02h", i, exp_q[i]);
            end else if (rx_got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL read_byte[%0d]: got %02h want %02h", i, rx_got_q[i], exp_q[i]);
            end
        end
        foreach (rd_width_q[i]) begin
            n_cmp++; if (rd_width_q[i] != RD_CYC) begin n_err++; $display("FAIL read_width[%0d]: got %0d want %0d", i, rd_width_q[i], RD_CYC); end
        end
        foreach (rd_gap_q[i]) begin
            n_cmp++; if (rd_gap_q[i] < REC_CYC) begin n_err++; $display("FAIL read_gap[%0d]: got %0d want >= %0d", i, rd_gap_q[i], REC_CYC); end
        end
        n_cmp++; if (rx_unstable != 0) begin n_err++; $display("FAIL read_data_stable: got %0d changes want 0", rx_unstable); end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL read_exclusive: got %0d violations want 0", viol); end
        ftdi_en = 1'b0;
        ftdi_q.delete();
    endtask

    task automatic test_rx_disabled();
        clear_mon();
        in_rx_en = 1'b0;
        ftdi_q.push_back(8'h11);
        ftdi_q.push_back(8'h22);
        ftdi_en = 1'b1;
        repeat (100) @(negedge in_clk);
        n_cmp++; if (rd_pulses != 0) begin n_err++; $display("FAIL rx_disabled_rd: got %0d pulses want 0", rd_pulses); end
        n_cmp++; if (req_cycles != 0) begin n_err++; $display("FAIL rx_disabled_req: got %0d req cycles want 0", req_cycles); end
        ftdi_en = 1'b0;
        ftdi_q.delete();
        repeat (2) @(negedge in_clk);
    endtask

    task automatic test_write_single(input logic [7:0] d);
        int lat;
        bit held, to;
        clear_mon();
        in_ftdi_txe = 1'b1;
        tx_transfer(d, $urandom_range(0, 3), lat, held, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL write_timeout: no ack for %02h", d); end
        n_cmp++; if (wr_pulses != 1) begin n_err++; $display("FAIL write_pulse_count: got %0d want 1", wr_pulses); end
        if (wr_width_q.size() != 0) begin
            n_cmp++; if (wr_width_q[0] != WR_CYC) begin n_err++; $display("FAIL write_width: got %0d want %0d", wr_width_q[0], WR_CYC); end
            n_cmp++; if (wr_pre_q[0] !== d) begin n_err++; $display("FAIL write_bus_setup: got %02h want %02h", wr_pre_q[0], d); end
            n_cmp++; if (wr_byte_q[0] !== d) begin n_err++; $display("FAIL write_bus_strobe: got %02h want %02h", wr_byte_q[0], d); end
            n_cmp++; if (wr_post_q[0] !== d) begin n_err++; $display("FAIL write_bus_hold: got %02h want %02h", wr_post_q[0], d); end
        end
        n_cmp++; if (!held) begin n_err++; $display("FAIL write_ack_held: ack dropped while req high"); end
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL write_ack_release: got %0d cycles want 1", lat); end
        n_cmp++; if (out_dbg.bus_oe !== 1'b0) begin n_err++; $display("FAIL write_bus_released: drive=%0b want 0", out_dbg.bus_oe); end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL write_exclusive: got %0d violations want 0", viol); end
        repeat (REC_CYC + 2) @(negedge in_clk);
    endtask

    task automatic test_write_txe_wait();
        int lat, wr_before, ack_before;
        bit held, to;
        logic [7:0] d;
        d = 8'($urandom);
        clear_mon();
        in_ftdi_txe = 1'b0;
        wr_before = -1;
        ack_before = -1;
        fork
            tx_transfer(d, 1, lat, held, to);
            begin
                repeat (50) @(negedge in_clk);
                wr_before  = wr_pulses;
                ack_before = ack_cycles;
                in_ftdi_txe = 1'b1;
            end
        join
        n_cmp++; if (wr_before != 0) begin n_err++; $display("FAIL txe_wait_no_wr: got %0d pulses want 0", wr_before); end
        n_cmp++; if (ack_before != 0) begin n_err++; $display("FAIL txe_wait_no_ack: got %0d ack cycles want 0", ack_before); end
        n_cmp++; if (to) begin n_err++; $display("FAIL txe_wait_timeout: write never acked"); end
        n_cmp++; if (wr_pulses != 1) begin n_err++; $display("FAIL txe_wait_pulses: got %0d want 1", wr_pulses); end
        if (wr_byte_q.size() != 0) begin
            n_cmp++; if (wr_byte_q[0] !== d) begin n_err++; $display("FAIL txe_wait_byte: got %02h want %02h", wr_byte_q[0], d); end
        end
        repeat (REC_CYC + 2) @(negedge in_clk);
    endtask

    task automatic test_back_to_back(input int nr, input int nw);
        logic [7:0] wexp[$];
        bit exp_ord[$];
        bit want_rd, to;
        int r, w, tx_to;
        do_reset(2);
        clear_mon();
        // Alternate while both kinds are pending, read first after reset
        r = nr; w = nw; want_rd = 1'b1;
        while (r > 0 || w > 0) begin
            if (r > 0 && (want_rd || w == 0)) begin exp_ord.push_back(1'b0); r--; want_rd = 1'b0; end
            else begin exp_ord.push_back(1'b1); w--; want_rd = 1'b1; end
        end
        for (int i = 0; i < nr; i++) begin
            exp_q.push_back(8'($urandom));
            ftdi_q.push_back(exp_q[i]);
        end
        for (int i = 0; i < nw; i++) wexp.push_back(8'($urandom));
        in_rx_en = 1'b1;
        in_ftdi_txe = 1'b1;
        ftdi_en = 1'b1;
        tx_to = 0;
        fork
            begin
                int lat;
                bit held, t;
                @(negedge in_clk);
                for (int i = 0; i < nw; i++) begin
                    tx_transfer(wexp[i], $urandom_range(0, 1), lat, held, t);
                    if (t) tx_to++;
                end
            end
        join
        wait_rx(nr, to);
        n_cmp++; if (to || tx_to != 0) begin n_err++; $display("FAIL b2b_timeout: rx=%0d/%0d tx_timeouts=%0d", rx_got_q.size(), nr, tx_to); end
        n_cmp++; if (order_q.size() != exp_ord.size()) begin n_err++; $display("FAIL b2b_count: got %0d transfers want %0d", order_q.size(), exp_ord.size()); end
        for (int i = 0; i < exp_ord.size() && i < order_q.size(); i++) begin
            n_cmp++; if (order_q[i] !== exp_ord[i]) begin n_err++; $display("FAIL b2b_order[%0d]: got %0d want %0d (0=rd 1=wr)", i, order_q[i], exp_ord[i]); end
        end
        for (int i = 0; i < nr && i < rx_got_q.size(); i++) begin
            n_cmp++; if (rx_got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_rx[%0d]: got %02h want %02h", i, rx_got_q[i], exp_q[i]); end
        end
        for (int i = 0; i < nw && i < wr_byte_q.size(); i++) begin
            n_cmp++; if (wr_byte_q[i] !== wexp[i]) begin n_err++; $display("FAIL b2b_wr[%0d]: got %02h want %02h", i, wr_byte_q[i], wexp[i]); end
        end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL b2b_exclusive: got %0d violations want 0", viol); end
        ftdi_en = 1'b0;
        ftdi_q.delete();
    endtask

    task automatic test_reset_abort();
        int c;
        // Read aborted mid-strobe
        clear_mon();
        ftdi_q.push_back(8'h77);
        in_rx_en = 1'b1;
        ftdi_en  = 1'b1;
        c = 0;
        while (!out_ftdi_rd && c < 200) begin @(negedge in_clk); c++; end
        n_cmp++; if (!out_ftdi_rd) begin n_err++; $display("FAIL abort_rd_start: rd never rose"); end
        @(negedge in_clk);
        in_rst = 1'b1;
        in_rx_en = 1'b0;
        ftdi_en = 1'b0;
        @(negedge in_clk);
        n_cmp++; if (out_ftdi_rd !== 1'b0) begin n_err++; $display("FAIL abort_rd_low: got %0b want 0", out_ftdi_rd); end
        n_cmp++; if (out_rx_data !== 8'h00) begin n_err++; $display("FAIL abort_rx_data: got %02h want 00", out_rx_data); end
        n_cmp++; if (out_dbg.state !== IDLE) begin n_err++; $display("FAIL abort_rd_state: got %0d want %0d", out_dbg.state, IDLE); end
        in_rst = 1'b0;
        ftdi_q.delete();
        repeat (20) @(negedge in_clk);
        n_cmp++; if (req_cycles != 0 || rx_got_q.size() != 0) begin n_err++; $display("FAIL abort_rd_delivered: req cycles %0d bytes %0d want 0", req_cycles, rx_got_q.size()); end
        // Write aborted mid-strobe
        clear_mon();
        in_ftdi_txe = 1'b1;
        in_tx_data = 8'h5A;
        in_tx_hsk_req = 1'b1;
        c = 0;
        while (!out_ftdi_wr && c < 200) begin @(negedge in_clk); c++; end
        n_cmp++; if (!out_ftdi_wr) begin n_err++; $display("FAIL abort_wr_start: wr never rose"); end
        @(negedge in_clk);
        in_rst = 1'b1;
        in_ftdi_txe = 1'b0;
        @(negedge in_clk);
        n_cmp++; if (out_ftdi_wr !== 1'b0) begin n_err++; $display("FAIL abort_wr_low: got %0b want 0", out_ftdi_wr); end
        n_cmp++; if (out_dbg.bus_oe !== 1'b0) begin n_err++; $display("FAIL abort_bus_z: drive=%0b want 0", out_dbg.bus_oe); end
        in_rst = 1'b0;
        repeat (20) @(negedge in_clk);
        n_cmp++; if (ack_cycles != 0) begin n_err++; $display("FAIL abort_wr_acked: got %0d ack cycles want 0", ack_cycles); end
        in_tx_hsk_req = 1'b0;
        repeat (2) @(negedge in_clk);
    endtask

    initial begin
        test_reset();
        test_read_stream(4, 1'b0);
        test_read_stream(6, 1'b1);
        test_rx_disabled();
        test_write_single(8'hA5);
        test_write_single(8'($urandom));
        test_write_txe_wait();
        test_back_to_back(4, 4);
        test_back_to_back(5, 3);
        test_back_to_back(2, 4);
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
